// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: pedestrian push-button front end for a traffic-light
// controller. Synchronizes and debounces the button, produces a tick
// timebase, and tracks a pending pedestrian request until the next RED
// entry serves it.
// Optional feature macro: PED_WAIT_LED_EN adds a wait_led output that
// blinks (toggles per tick) while a request is pending.
module ped_request_ctrl #(
  parameter int unsigned DIV     = 10,
  parameter int unsigned DEB_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_raw,
  input  logic [2:0] light_state,
  output logic       tick,
  output logic       btn_press,
  output logic       ped_req,
`ifdef PED_WAIT_LED_EN
  output logic       wait_led,
`endif
  output logic [3:0] ped_count
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [7:0]  DEB_LAST = 8'(DEB_CYC - 1);
  localparam logic [2:0]  LIGHT_RED = 3'd1;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVED  = 2'd2
  } state_t;

  logic [15:0] div_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        deb_q;
  logic [7:0]  stab_q;
  logic        btn_press_q;
  logic [2:0]  light_prev_q;
  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        red_entry;
  logic [3:0]  count_inc;

  // Prescaler: free-running 0..DIV-1 counter, frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else if (ena) begin
      if (div_q == DIV_LAST) div_q <= '0;
      else                   div_q <= div_q + 16'd1;
    end
  end

  assign tick = ena && (div_q == DIV_LAST);

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else if (ena) begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debouncer: flip deb once sync has disagreed for DEB_CYC straight cycles;
  // the press pulse is registered alongside the rising flip of deb.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q       <= 1'b0;
      stab_q      <= '0;
      btn_press_q <= 1'b0;
    end else if (ena) begin
      btn_press_q <= 1'b0;
      if (sync2_q != deb_q) begin
        if (stab_q == DEB_LAST) begin
          deb_q       <= ~deb_q;
          stab_q      <= '0;
          btn_press_q <= ~deb_q;
        end else begin
          stab_q <= stab_q + 8'd1;
        end
      end else begin
        stab_q <= '0;
      end
    end
  end

  // A pulse captured just before ena dropped is held, so masking keeps the
  // output quiet while frozen and lets it show (and be consumed) on resume.
  assign btn_press = btn_press_q && ena;

  assign red_entry = (light_state == LIGHT_RED) && (light_prev_q != LIGHT_RED);
  assign count_inc = (count_q == 4'd15) ? count_q : count_q + 4'd1;

  // Request FSM state, press counter and previous light state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WAIT;
      count_q      <= '0;
      light_prev_q <= '0;
    end else if (ena) begin
      state_q      <= state_d;
      count_q      <= count_d;
      light_prev_q <= light_state;
    end
  end

  // Next-state and counter logic; RED entry beats a coincident press.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_WAIT: begin
        if (btn_press_q) begin
          state_d = ST_PENDING;
          count_d = count_inc;
        end
      end
      ST_PENDING: begin
        if (red_entry) begin
          state_d = ST_SERVED;
          count_d = '0;
        end else if (btn_press_q) begin
          count_d = count_inc;
        end
      end
      ST_SERVED: begin
        if (light_state != LIGHT_RED) state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  assign ped_req   = (state_q == ST_PENDING);
  assign ped_count = count_q;

`ifdef PED_WAIT_LED_EN
  logic led_q;

  // Wait LED: set on PENDING entry, toggled per tick while PENDING, else 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= 1'b0;
    end else if (ena) begin
      if (state_d != ST_PENDING)      led_q <= 1'b0;
      else if (state_q != ST_PENDING) led_q <= 1'b1;
      else if (tick)                  led_q <= ~led_q;
    end
  end

  assign wait_led = led_q;
`endif

endmodule

// File: doc/ped_request_ctrl.md
PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 10, meaning clk cycles per tick period (range 2..65535).
REQ-002 SHALL have parameter DEB_CYC, default 4, meaning consecutive stable cycles required to accept a button level change (range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port ena  input  1  global enable; when low, all internal state holds and tick is low.
REQ-006 SHALL have port btn_raw  input  1  asynchronous pedestrian push-button, active-high.
REQ-007 SHALL have port light_state  input  3  traffic-light controller state: 0 IDLE, 1 RED, 2 RED_YELLOW, 3 GREEN, 4 GREEN_BLINK, 5 YELLOW; 6 and 7 are treated as non-RED.
REQ-008 SHALL have port tick  output  1  one-cycle timebase pulse, once per DIV cycles.
REQ-009 SHALL have port btn_press  output  1  one-cycle pulse on each accepted button press.
REQ-010 SHALL have port ped_req  output  1  pedestrian request pending, as a level.
REQ-011 SHALL have port ped_count  output  4  number of presses since the last service, saturating.

Function
REQ-012 SHALL pass btn_raw through a 2-flop synchronizer; only the second-stage output (sync) is used.
REQ-013 SHALL run the prescaler from 0 to DIV-1 while ena=1; tick=1 in the cycle where the count equals DIV-1; the count wraps to 0 on the next edge.
REQ-014 SHALL run the debouncer as follows: the debounced level deb toggles on the edge at which sync has differed from deb for DEB_CYC consecutive cycles; any cycle with sync==deb clears the stability counter.
REQ-015 SHALL assert btn_press (registered) for exactly one cycle, coincident with the first cycle deb=1; a falling deb produces no pulse.
REQ-016 SHALL produce latency such that btn_raw held high from edge k gives btn_press=1 after edge k+1+DEB_CYC and ped_req=1 after edge k+2+DEB_CYC.
REQ-017 SHALL implement the request FSM with states WAIT, PENDING and SERVED; reset state is WAIT.
REQ-018 SHALL transition WAIT->PENDING on btn_press.
REQ-019 SHALL transition PENDING->SERVED on RED entry, defined as light_state==1 this cycle and !=1 in the previous cycle.
REQ-020 SHALL transition SERVED->WAIT on the first cycle light_state!=1.
REQ-021 SHALL drive ped_req=1 only in PENDING.
REQ-022 SHALL, in WAIT and PENDING, increment ped_count by 1 on btn_press, saturating at 15.
REQ-023 SHALL clear ped_count on entry to SERVED.
REQ-024 SHALL ignore presses in SERVED: no state change, no count change; btn_press still pulses.
REQ-025 SHALL give priority to RED entry when btn_press and RED entry coincide in PENDING: the press is discarded and ped_count is cleared.
REQ-026 SHALL NOT treat light_state==1 already present while in WAIT as RED entry for a subsequent press; the next RED entry is required.
REQ-027 SHALL, with ena=0, freeze the prescaler, synchronizer, debouncer, FSM and count; tick and btn_press are 0.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear the prescaler, synchronizer, deb, stability counter, FSM (to WAIT), previous light_state (taken as 0) and ped_count.
REQ-029 SHALL hold tick, btn_press, ped_req and ped_count at 0 in the cycle after reset, and SHALL apply reset mid-count or mid-debounce identically, with rst overriding ena.

Configuration
REQ-030 SHALL provide macro PED_WAIT_LED_EN; when defined, output wait_led (1 bit) is added: it is 0 outside PENDING and toggles on every tick while in PENDING, starting at 1 on PENDING entry.
REQ-031 SHALL, without PED_WAIT_LED_EN, not have the wait_led port; all other behaviour is identical.

Verification
REQ-032 SHALL verify: DIV=10, ena=1 for 35 cycles after reset -> tick pulses at cycles 9, 19 and 29 only.
REQ-033 SHALL verify: DEB_CYC=4, btn_raw high from edge 0 -> btn_press at cycle 5, ped_req=1 at cycle 6, ped_count=1.
REQ-034 SHALL verify: btn_raw glitch high for 3 cycles -> no btn_press, ped_req stays 0.
REQ-035 SHALL verify: PENDING, light_state 5->1 -> ped_req falls next cycle, ped_count=0; a press while light_state=1 -> ped_count stays 0; light_state 1->3 -> WAIT.
REQ-036 SHALL verify: 17 debounced presses in WAIT/PENDING -> ped_count=15.
REQ-037 SHALL verify: rst pulsed mid-debounce with ped_req=1 -> all outputs 0 next cycle; ena=0 for 20 cycles -> no tick and count frozen.
